// File: rtl/nexys_bcd_7seg_encoder_pkg.sv
// rtl/nexys_bcd_7seg_encoder_pkg.sv - shared types, constants and segment decode for the BCD 7-seg encoder
package nexys_7seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam logic [26:0] MAX_DEC = 27'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ENCODE
    } state_t;

    // Active-low gfedcba; any non-decimal nibble shows as a dash.
    function automatic seg_t bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/nexys_bcd_7seg_encoder_if.sv
// rtl/nexys_bcd_7seg_encoder_if.sv - value handshake and segment-pattern bus of the encoder
interface nexys_bcd_7seg_encoder_if #(
    parameter int WIDTH = 27
);
    import nexys_7seg_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    seg_t             segs [8];
    logic             done;

    modport master (output in_valid, output in_value, input in_ready, input segs, input done);
    modport slave  (input in_valid, input in_value, output in_ready, output segs, output done);

endinterface

// File: rtl/nexys_bcd_7seg_encoder_bin2bcd.sv
// rtl/nexys_bcd_7seg_encoder_bin2bcd.sv - sequential double-dabble, one input bit per clock
module bin2bcd_seq
    import nexys_7seg_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      bcd_o
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d, adj;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 8; i++) begin
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {adj[30:0], bin_q[WIDTH-1]};
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_ENCODE;
            end
            ST_ENCODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_ENCODE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/nexys_bcd_7seg_encoder.sv
// rtl/nexys_bcd_7seg_encoder.sv - binary to eight active-low 7-seg patterns with blanking and overflow dashes
module nexys_bcd_7seg_encoder
    import nexys_7seg_pkg::*;
#(
    parameter int WIDTH         = 27,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nexys_bcd_7seg_encoder_if.slave   bus
);

    logic        start, busy, conv_done;
    logic [31:0] bcd;
    logic        ovf_q, ovf_d;
    logic        done_q;
    seg_t        segs_q [8];
    seg_t        segs_d [8];
    logic        lead_zero;

    assign start = bus.in_valid && !busy;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (bus.in_value),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (start) ovf_d = (32'(bus.in_value) > 32'(MAX_DEC));
    end

    // Walk from the most significant digit down so lead_zero means "this and all higher nibbles are 0".
    always_comb begin
        lead_zero = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            lead_zero = lead_zero && (bcd[k*4 +: 4] == 4'd0);
            if (ovf_q)
                segs_d[k] = SEG_DASH;
            else if (BLANK_LEADING && (k != 0) && lead_zero)
                segs_d[k] = SEG_BLANK;
            else
                segs_d[k] = bcd_to_seg(bcd[k*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            for (int k = 0; k < 8; k++) segs_q[k] <= SEG_BLANK;
        end else begin
            ovf_q  <= ovf_d;
            done_q <= conv_done;
            if (conv_done) begin
                for (int k = 0; k < 8; k++) segs_q[k] <= segs_d[k];
            end
        end
    end

    assign bus.in_ready = !busy;
    assign bus.done     = done_q;
    assign bus.segs     = segs_q;

endmodule

// File: tb/tb_nexys_bcd_7seg_encoder.sv
// tb/tb_nexys_bcd_7seg_encoder.sv - scoreboard bench for the BCD 7-seg encoder, blanking on and off
module tb_nexys_bcd_7seg_encoder;
    import nexys_7seg_pkg::*;

    localparam int W = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nexys_bcd_7seg_encoder_if #(.WIDTH(W)) bif1 ();
    nexys_bcd_7seg_encoder_if #(.WIDTH(W)) bif0 ();

    nexys_bcd_7seg_encoder #(.WIDTH(W), .BLANK_LEADING(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bif1.slave));
    nexys_bcd_7seg_encoder #(.WIDTH(W), .BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0.slave));

    int          tests = 0;
    int          fails = 0;
    logic [55:0] q1 [$];
    logic [55:0] q0 [$];
    logic [55:0] a1, a0;
    int          n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit which);
        return which ? bif0.in_ready : bif1.in_ready;
    endfunction

    task automatic send(input bit which, input int v, input bit push, input logic [55:0] exp);
        int k = 0;
        while (!rdy(which) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("send ready timeout", 64'(k), 64'(0));
        if (push) begin
            if (which) q0.push_back(exp);
            else       q1.push_back(exp);
        end
        if (which) begin bif0.in_value = W'(v); bif0.in_valid = 1'b1; end
        else       begin bif1.in_value = W'(v); bif1.in_valid = 1'b1; end
        @(negedge clk);
        bif0.in_valid = 1'b0;
        bif1.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        int k = 0;
        while (!rdy(which) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("idle timeout", 64'(k), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        bif1.in_valid = 1'b0; bif1.in_value = '0;
        bif0.in_valid = 1'b0; bif0.in_value = '0;

        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    a1[i*7 +: 7] = bif1.segs[i];
                    a0[i*7 +: 7] = bif0.segs[i];
                end
                if (bif1.done === 1'b1) begin
                    if (q1.size() == 0) check("dut1 spurious done", 64'(q1.size()), 64'(1));
                    else                check("dut1 segs", 64'(a1), 64'(q1.pop_front()));
                end
                if (bif0.done === 1'b1) begin
                    if (q0.size() == 0) check("dut0 spurious done", 64'(q0.size()), 64'(1));
                    else                check("dut0 segs", 64'(a0), 64'(q0.pop_front()));
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset segs", 64'(a1), 64'({8{7'h7F}}));
        check("reset in_ready", 64'(bif1.in_ready), 64'(1));
        check("reset done", 64'(bif1.done), 64'(0));

        send(0, 0, 1, {{7{7'h7F}}, 7'h40});
        wait_idle(0);

        send(0, 12_345_678, 1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
        n = 0;
        while (!bif1.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("in_ready low cycles", 64'(n), 64'(W + 1));
        @(negedge clk);

        send(0, 100_000_000, 1, {8{7'h3F}});
        wait_idle(0);
        send(0, 99_999_999, 1, {8{7'h10}});
        wait_idle(0);
        send(0, 42, 1, {{6{7'h7F}}, 7'h19, 7'h24});
        wait_idle(0);
        send(0, 100_000, 1, {7'h7F, 7'h7F, 7'h79, {5{7'h40}}});
        wait_idle(0);

        send(1, 42, 1, {{6{7'h40}}, 7'h19, 7'h24});
        for (int i = 0; i < 6; i++) begin
            bif0.in_value = W'(99);
            bif0.in_valid = i[0];
            @(negedge clk);
        end
        bif0.in_valid = 1'b0;
        wait_idle(1);
        send(1, 0, 1, {8{7'h40}});
        wait_idle(1);

        send(0, 12_345_678, 0, '0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort segs", 64'(a1), 64'({8{7'h7F}}));
        check("abort in_ready", 64'(bif1.in_ready), 64'(1));
        repeat (40) @(negedge clk);

        send(0, 7, 1, {{7{7'h7F}}, 7'h78});
        wait_idle(0);

        repeat (5) @(negedge clk);
        check("dut1 queue drained", 64'(q1.size()), 64'(0));
        check("dut0 queue drained", 64'(q0.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
